// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter and sequencer that shares one 8x8 multiplier
// between NUM_REQ requesters. Each grant captures one operand pair, pulses
// mul_start, waits for mul_done and returns the product as a one-hot response.
// Optional build macro MUL_ARB_TIMEOUT_EN adds a WAIT-state watchdog. When the
// watchdog fires, the response carries 16'hFFFF and the extra resp_err port pulses.
module mul_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [15:0]            resp_y,
  output logic                   mul_start,
  output logic [7:0]             mul_a,
  output logic [7:0]             mul_b,
  input  logic [15:0]            mul_y,
  input  logic                   mul_done,
  output logic                   busy
`ifdef MUL_ARB_TIMEOUT_EN
  ,
  output logic                   resp_err
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Out-of-range parameters leave this marker block in the elaborated netlist.
  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_range_error
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [7:0]            mul_a_q, mul_a_d;
  logic [7:0]            mul_b_q, mul_b_d;
  logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic [15:0]           resp_y_q, resp_y_d;
  logic [NUM_REQ-1:0]    req_ready_s;
  logic [IDX_W:0]        pick_s;
  logic                  pick_found_s;
  logic [IDX_W-1:0]      pick_idx_s;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]            cnt_q, cnt_d;
  logic                  resp_err_q, resp_err_d;
`endif

  // Round-robin scan: the first valid index starting at ptr and wrapping at NUM_REQ.
  // The scan runs from the far end back to ptr, so the nearest valid index is written last and wins.
  // Result MSB = found flag, low bits = winning index.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] sel;
    int               idx;
    res = {(IDX_W+1){1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      sel = idx[IDX_W-1:0];
      if (valid[sel]) begin
        res = {1'b1, sel};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Index that follows idx, wrapping from NUM_REQ-1 back to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    if (idx == IDX_W'(NUM_REQ - 1)) begin
      nxt = {IDX_W{1'b0}};
    end else begin
      nxt = idx + {{(IDX_W-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

  assign pick_s       = rr_pick(req_valid, rr_ptr_q);
  assign pick_found_s = pick_s[IDX_W];
  assign pick_idx_s   = pick_s[IDX_W-1:0];

  // Next-state and datapath decode for the IDLE -> ISSUE -> WAIT sequence.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    resp_valid_d = {NUM_REQ{1'b0}};
    resp_y_d     = resp_y_q;
    req_ready_s  = {NUM_REQ{1'b0}};
`ifdef MUL_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    resp_err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found_s) begin
          req_ready_s[pick_idx_s] = 1'b1;
          mul_a_d                 = req_a[{pick_idx_s, 3'b000} +: 8];
          mul_b_d                 = req_b[{pick_idx_s, 3'b000} +: 8];
          grant_d                 = pick_idx_s;
          state_d                 = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      S_WAIT: begin
        if (mul_done) begin
          resp_y_d              = mul_y;
          resp_valid_d[grant_q] = 1'b1;
          rr_ptr_d              = next_idx(grant_q);
          state_d               = S_IDLE;
        end else begin
`ifdef MUL_ARB_TIMEOUT_EN
          if (cnt_q == TO_LAST) begin
            resp_y_d              = 16'hFFFF;
            resp_valid_d[grant_q] = 1'b1;
            resp_err_d            = 1'b1;
            rr_ptr_d              = next_idx(grant_q);
            state_d               = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = S_WAIT;
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= {IDX_W{1'b0}};
      grant_q      <= {IDX_W{1'b0}};
      mul_a_q      <= 8'd0;
      mul_b_q      <= 8'd0;
      resp_valid_q <= {NUM_REQ{1'b0}};
      resp_y_q     <= 16'd0;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q        <= 8'd0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      resp_valid_q <= resp_valid_d;
      resp_y_q     <= resp_y_d;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  // req_ready is held low while reset is asserted, even if a requester is valid.
  assign req_ready  = req_ready_s & {NUM_REQ{~rst}};
  assign resp_valid = resp_valid_q;
  assign resp_y     = resp_y_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_start  = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE);
`ifdef MUL_ARB_TIMEOUT_EN
  assign resp_err   = resp_err_q;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter (NUM_REQ=4). A simple multiplier model answers
// each mul_start one cycle later, unless the model is disabled. Inputs are driven
// and outputs are sampled on the falling clock edge.
module tb_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = 4'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [15:0] resp_y;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_y;
  logic        mul_done;
  logic        busy;
`ifdef MUL_ARB_TIMEOUT_EN
  logic        resp_err;
`endif

  logic        model_en = 1'b1;
  logic        manual_done = 1'b0;
  logic        mul_done_m = 1'b0;
  logic [15:0] mul_y_m = 16'd0;

  int errors = 0;
  int checks = 0;

  mul_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_y     (resp_y),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_y      (mul_y),
    .mul_done   (mul_done),
    .busy       (busy)
`ifdef MUL_ARB_TIMEOUT_EN
    ,
    .resp_err   (resp_err)
`endif
  );

  always #5 clk = ~clk;

  // Multiplier model: done one cycle after start, product of the registered operands.
  always @(posedge clk) begin
    mul_done_m <= mul_start & model_en;
    mul_y_m    <= 16'(mul_a) * 16'(mul_b);
  end
  assign mul_done = mul_done_m | manual_done;
  assign mul_y    = mul_y_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  // One full transaction, starting in the handshake cycle just after a falling edge.
  task automatic run_op(input int g, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [15:0] ey, input bit drop);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    #1;
    chk("ready_grant", {28'd0, req_ready}, {28'd0, oh});
    chk("busy_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("start_issue", {31'd0, mul_start}, 32'd1);
    chk("mul_a", {24'd0, mul_a}, {24'd0, ea});
    chk("mul_b", {24'd0, mul_b}, {24'd0, eb});
    chk("ready_issue", {28'd0, req_ready}, 32'd0);
    chk("busy_issue", {31'd0, busy}, 32'd1);
    if (drop) req_valid[g] = 1'b0;
    @(negedge clk);
    chk("start_wait", {31'd0, mul_start}, 32'd0);
    chk("resp_wait", {28'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("resp_valid", {28'd0, resp_valid}, {28'd0, oh});
    chk("resp_y", {16'd0, resp_y}, {16'd0, ey});
    chk("busy_done", {31'd0, busy}, 32'd0);
`ifdef MUL_ARB_TIMEOUT_EN
    chk("resp_err_ok", {31'd0, resp_err}, 32'd0);
`endif
  endtask

  initial begin
    // Reset state; a valid request during reset must not be accepted.
    req_valid = 4'b0001;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
    chk("rst_resp_y", {16'd0, resp_y}, 32'd0);
    chk("rst_mul_start", {31'd0, mul_start}, 32'd0);
    chk("rst_mul_a", {24'd0, mul_a}, 32'd0);
    chk("rst_mul_b", {24'd0, mul_b}, 32'd0);
    req_valid = 4'b0000;
    rst = 1'b0;
    @(negedge clk);

    // Round-robin with all four continuously valid: order 0,1,2,3,0, back to back.
    set_req(0, 8'd2, 8'd3);
    set_req(1, 8'd4, 8'd5);
    set_req(2, 8'd100, 8'd200);
    set_req(3, 8'd16, 8'd16);
    req_valid = 4'b1111;
    run_op(0, 8'd2, 8'd3, 16'd6, 1'b0);
    run_op(1, 8'd4, 8'd5, 16'd20, 1'b0);
    run_op(2, 8'd100, 8'd200, 16'd20000, 1'b0);
    run_op(3, 8'd16, 8'd16, 16'd256, 1'b0);
    run_op(0, 8'd2, 8'd3, 16'd6, 1'b0);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    chk("resp_y_hold", {16'd0, resp_y}, 32'd6);
    chk("resp_valid_pulse", {28'd0, resp_valid}, 32'd0);

    // Single request on req0 (rr_ptr=1, scan wraps to 0): 12*10=120.
    set_req(0, 8'd12, 8'd10);
    req_valid = 4'b0001;
    run_op(0, 8'd12, 8'd10, 16'd120, 1'b1);

    // req1 alone moves rr_ptr to 2: 3*7=21.
    set_req(1, 8'd3, 8'd7);
    req_valid = 4'b0010;
    run_op(1, 8'd3, 8'd7, 16'd21, 1'b1);

    // Contention req1+req3 with rr_ptr=2: req3 first, then req1.
    set_req(3, 8'd11, 8'd13);
    req_valid = 4'b1010;
    run_op(3, 8'd11, 8'd13, 16'd143, 1'b1);
    run_op(1, 8'd3, 8'd7, 16'd21, 1'b1);

    // Max operands on req2: 255*255=65025.
    set_req(2, 8'd255, 8'd255);
    req_valid = 4'b0100;
    run_op(2, 8'd255, 8'd255, 16'd65025, 1'b1);

    // Reset in WAIT: the transaction is abandoned and a late mul_done is ignored.
    model_en = 1'b0;
    set_req(3, 8'd9, 8'd9);
    req_valid = 4'b1000;
    #1;
    chk("mid_ready", {28'd0, req_ready}, 32'h8);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("mid_busy_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    set_req(0, 8'd5, 8'd6);
    req_valid = 4'b0001;
    #1;
    chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_resp_valid", {28'd0, resp_valid}, 32'd0);
    chk("mid_resp_y", {16'd0, resp_y}, 32'd0);
    chk("mid_mul_a", {24'd0, mul_a}, 32'd0);
    chk("mid_mul_start", {31'd0, mul_start}, 32'd0);
    rst = 1'b0;
    req_valid = 4'b0000;
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    chk("late_done_resp", {28'd0, resp_valid}, 32'd0);
    chk("late_done_busy", {31'd0, busy}, 32'd0);
    model_en = 1'b1;
    req_valid = 4'b0001;
    run_op(0, 8'd5, 8'd6, 16'd30, 1'b1);

`ifdef MUL_ARB_TIMEOUT_EN
    // Timeout: no mul_done, response after 15 WAIT cycles with the error marker.
    begin
      int  n_seen;
      bit  seen;
      seen   = 1'b0;
      n_seen = 0;
      model_en = 1'b0;
      set_req(1, 8'd1, 8'd1);
      req_valid = 4'b0010;
      #1;
      chk("to_ready", {28'd0, req_ready}, 32'h2);
      @(negedge clk);
      req_valid = 4'b0000;
      for (int n = 1; n <= 40 && !seen; n++) begin
        @(negedge clk);
        if (resp_valid != 4'd0) begin
          seen   = 1'b1;
          n_seen = n;
        end
      end
      chk("to_seen", {31'd0, seen}, 32'd1);
      chk("to_latency", n_seen, 32'd16);
      chk("to_resp_valid", {28'd0, resp_valid}, 32'h2);
      chk("to_resp_y", {16'd0, resp_y}, 32'hFFFF);
      chk("to_resp_err", {31'd0, resp_err}, 32'd1);
      chk("to_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("to_err_pulse", {31'd0, resp_err}, 32'd0);
      model_en = 1'b1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Run-time bound in case the design stalls somewhere unexpected.
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
Round-robin arbiter and sequencer sharing one 8x8 multiplier unit among NUM_REQ requesters.
- Accepts one operand pair per grant through a valid/ready handshake.
- Issues a single-cycle start pulse to the multiplier and waits for its done pulse.
- Returns the 16-bit product to the granted requester as a one-cycle response pulse.
- Sits between client engines (e.g. MAC or dot-product sequencers) and the shared multiplier.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
TIMEOUT_CYCLES, 15, WAIT-state cycle limit; used only with the optional feature; legal range 1..255.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester operand valid.
req_a  in  8*NUM_REQ  operand a; requester i occupies bits [8i+7:8i].
req_b  in  8*NUM_REQ  operand b; same packing as req_a.
req_ready  out  NUM_REQ  one-hot accept strobe (combinational).
resp_valid  out  NUM_REQ  one-hot registered result strobe.
resp_y  out  16  product; valid while any resp_valid bit is high.
mul_start  out  1  start pulse to the multiplier.
mul_a  out  8  operand a to the multiplier (registered).
mul_b  out  8  operand b to the multiplier (registered).
mul_y  in  16  multiplier product.
mul_done  in  1  multiplier completion pulse; arrives one cycle after mul_start.
busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, rr_ptr=0, grant register=0.
  - mul_a=0, mul_b=0, resp_valid=0, resp_y=0.
  - mul_start=0, req_ready=0, busy=0.
  - Reset mid-operation abandons the transaction: no resp_valid is produced, and a late mul_done is ignored.
- States:
  - IDLE: if any req_valid is high, the winner g is the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. req_ready[g]=1 combinationally this cycle. Next edge: mul_a<=req_a[g], mul_b<=req_b[g], grant<=g, state<=ISSUE. If no request is valid: stay in IDLE, all req_ready=0.
  - ISSUE: mul_start=1 for exactly this cycle; next state WAIT.
  - WAIT: on mul_done=1, next edge: resp_y<=mul_y, resp_valid[grant]<=1 for exactly one cycle, rr_ptr<=(grant+1) mod NUM_REQ, state<=IDLE. Without mul_done, stay in WAIT.
- Timing: handshake at cycle T; mul_start at T+1; mul_done at T+2; resp_valid at T+3. The next accept is possible at T+3, the same cycle as resp_valid, so throughput is one operation per 3 cycles.
- resp_y holds its last value between responses.
- req_ready is never asserted outside IDLE and never more than one bit at a time.
- Requesters must hold req_a/req_b stable while req_valid=1 and req_ready=0. Operands are captured only on the handshake cycle.
- Deasserting req_valid before the grant is legal; that request is simply not served.
- A requester may reissue in the same cycle its resp_valid is high.
- Fairness: after serving g, g has the lowest priority. Any continuously valid requester is granted within NUM_REQ grants.
- mul_done outside WAIT is ignored.
- Product width is 16 bits, unsigned, with no truncation (255*255=65025 fits).
- Wrap-around: rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
MUL_ARB_TIMEOUT_EN
- When defined:
  - An 8-bit counter runs in WAIT. If it reaches TIMEOUT_CYCLES without mul_done, the block returns to IDLE.
  - On timeout: resp_valid[grant] pulses with resp_y=16'hFFFF, and an extra output port resp_err (1 bit) pulses in the same cycle. rr_ptr advances as normal.
  - resp_err resets to 0. The counter clears on entry to WAIT.
- When undefined: no counter and no resp_err port; WAIT waits indefinitely.

Test Plan:
- Single request: req0 a=12, b=10 at T -> req_ready[0] at T; mul_start at T+1; with the bench multiplier model, resp_valid[0] at T+3 with resp_y=120.
- Max operands: a=255, b=255 on req 2 -> resp_y=65025, resp_valid=4'b0100.
- Round-robin: all four requesters continuously valid -> grant order 0,1,2,3,0. After 3, rr_ptr wraps to 0. Each product is routed to the correct requester.
- Contention after a grant: req1 and req3 valid with rr_ptr=2 -> req3 is granted first, then req1.
- Reset mid-operation: rst asserted in WAIT -> no resp_valid; all outputs return to reset values next cycle; a late mul_done is ignored; a new request completes normally.
- Timeout (MUL_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=15): multiplier model never raises mul_done -> resp_valid pulses with resp_err=1 and resp_y=16'hFFFF, and the block returns to IDLE.
